txs_burst_arbiter: RTL and testbench
====================================

# txs_burst_arbiter

Round-robin arbiter that shares the single Avalon-MM burst-write master port (txs_*) between NREQ DMA requesters, e.g. camera 0, camera 1 and the corner/IMU stream. It sits in `top` between the per-source write FIFOs and the PCIe TX slave. It grants one whole burst at a time and streams that requester's show-ahead FIFO onto txs_writedata, honouring txs_waitrequest.

## Interface
- NREQ, 2: number of requesters, 2..4
- AW, 23: txs_address width, passed through unchanged
- DW, 128: data width
- BW, 6: burstcount width
- MAX_BURST, 32: largest legal burstcount
- clk125  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- req_valid  in  NREQ  requester holds a complete burst in its FIFO
- req_addr  in  NREQ*AW  burst start address, stable while req_valid
- req_burstcount  in  NREQ*BW  beats in the burst, 0..MAX_BURST
- req_data  in  NREQ*DW  show-ahead FIFO head word
- req_grant  out  NREQ  one-hot; held for the whole burst
- req_rd  out  NREQ  pop strobe, one per accepted beat
- req_done  out  NREQ  one-cycle pulse with the last pop, or for a zero-length grant
- txs_write  out  1  Avalon write
- txs_address  out  AW  latched burst address
- txs_burstcount  out  BW  latched burstcount
- txs_writedata  out  DW  granted requester's req_data
- txs_waitrequest  in  1  Avalon stall
- stat_bursts  out  NREQ*16  per-requester completed-burst counters (see Configuration)

## Operation
- FSM states are IDLE, BURST and ZERO. Reset state is IDLE.
- IDLE: if any req_valid is high, pick the first valid requester after last_grant (circular order) and register its req_grant bit, address, burstcount and beats_left = burstcount. Go to BURST, or to ZERO if burstcount == 0. With no valid requester, stay in IDLE.
- BURST: txs_write = 1. txs_address and txs_burstcount are held constant for the whole burst, not only on the first beat.
- A beat is accepted when txs_write & ~txs_waitrequest. An accepted beat pulses req_rd[g] (combinational) and decrements beats_left.
- Last accepted beat (beats_left == 1): req_done[g] pulses in the same cycle as the final req_rd. last_grant <= g. Next state is IDLE; req_grant and txs_write clear at that edge.
- ZERO: no txs beat is issued. req_done[g] pulses for one cycle, last_grant <= g, then the FSM returns to IDLE.
- burstcount > MAX_BURST is clamped to MAX_BURST.
- txs_writedata is a combinational mux from req_data[g]. It stays stable during stall because the FIFO head only changes on req_rd.
- req_valid changes during BURST are ignored until IDLE.
- Reset values: txs_write = 0, txs_address = 0, txs_burstcount = 0, req_grant = 0, req_rd = 0, req_done = 0, stat_bursts = 0.
- last_grant resets to NREQ-1, so requester 0 wins first.
- Asserting rst mid-burst drops txs_write immediately. The Avalon slave is reset by the same rst.

## Timing
- req_valid is sampled at edge k in IDLE. req_grant and txs_write are high from cycle k+1, and the first beat can be accepted in cycle k+1.
- An N-beat burst without stall occupies N cycles, followed by exactly one IDLE cycle.
- Back-to-back bursts from different requesters therefore have a period of N+1 cycles.
- Requesters must clear or update req_valid/req_addr on the edge where req_done is high, so that the IDLE cycle samples fresh values.
- Every waitrequest cycle adds one cycle to the burst. Outputs hold.
- txs_write, txs_address, txs_burstcount and req_grant are registered. req_rd, req_done and txs_writedata are combinational.

## Configuration
- TXS_ARB_STATS_EN defined: stat_bursts[i] is a 16-bit counter that increments on each req_done[i], including zero-length grants, and wraps at 0xFFFF → 0.
- TXS_ARB_STATS_EN not defined: stat_bursts is tied to 0 and no counter flops exist.

## Structure
- Package ovc_txs_pkg holds the state enum (IDLE/BURST/ZERO) and the default widths AW/DW/BW/MAX_BURST.
- Sub-module txs_rr_pick is a combinational round-robin selector: inputs req_valid and last_grant, outputs a one-hot pick and an any flag.
- Everything else lives in the arbiter.

## Test plan
- Single burst: req_valid[0], addr 0x1000, burstcount 4, waitrequest 0 → txs_write high 4 cycles with address 0x1000 and burstcount 4; req_rd[0] pulses 4 times; req_done[0] on the 4th; one IDLE cycle follows.
- Contention: both requesters continuously valid, burstcount 8 → grant order 0,1,0,1; each burst is 8 write cycles plus 1 gap; data words match each requester's FIFO order.
- Stall: waitrequest high 25 cycles, low 6, high 6, then low, during a 6-beat burst → exactly 6 accepted beats; txs_writedata, address and burstcount stable through stalls; req_rd only on accepted cycles.
- Zero-length: req_burstcount[1] = 0 → no txs_write; req_done[1] pulses once; next grant goes to requester 0.
- Reset mid-burst: rst at beat 3 of 8 → txs_write and req_grant drop in the same cycle. After release, the first grant goes to requester 0 with a full, fresh burst.
- Stats: 3 bursts on requester 0 and 2 on requester 1 → stat_bursts = {16'd2, 16'd3} with TXS_ARB_STATS_EN, and 0 without it.

Source files
------------

// File: rtl/ovc_txs_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ovc_txs_pkg
// Function : Shared FSM encoding and default widths for the txs burst arbiter.
// Revision : 1.0
// ============================================================================
package ovc_txs_pkg;

   localparam int c_AW        = 23;
   localparam int c_DW        = 128;
   localparam int c_BW        = 6;
   localparam int c_MAX_BURST = 32;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      BURST = 2'd1,
      ZERO  = 2'd2
   } txs_state_e;

endpackage
`default_nettype wire

// File: rtl/txs_rr_pick.sv
`default_nettype none
// ============================================================================
// Module   : txs_rr_pick
// Function : Combinational round-robin selector; picks the first valid
//            requester strictly after last_grant in circular order.
// Revision : 1.0
// ============================================================================
module txs_rr_pick #(
   parameter int NREQ = 2,
   parameter int GW   = 1
)(
   input  logic [NREQ-1:0] req_valid,
   input  logic [GW-1:0]   last_grant,
   output logic [NREQ-1:0] pick,
   output logic            any
);

   // Walk the ring from farthest to nearest so the nearest valid slot wins.
   always_comb begin
      pick = '0;
      any  = |req_valid;
      for (int k = NREQ; k >= 1; k--) begin
         for (int j = 0; j < NREQ; j++) begin
            if ((j == ((int'(last_grant) + k) % NREQ)) && req_valid[j]) begin
               pick    = '0;
               pick[j] = 1'b1;
            end
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/txs_burst_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : txs_burst_arbiter
// Function : Burst-granular round-robin arbiter onto the txs Avalon-MM write
//            master. Define TXS_ARB_STATS_EN to build per-requester counters.
// Revision : 1.0
// ============================================================================
module txs_burst_arbiter
   import ovc_txs_pkg::*;
#(
   parameter int NREQ      = 2,
   parameter int AW        = c_AW,
   parameter int DW        = c_DW,
   parameter int BW        = c_BW,
   parameter int MAX_BURST = c_MAX_BURST
)(
   input  logic                 clk125,
   input  logic                 rst,
   input  logic [NREQ-1:0]      req_valid,
   input  logic [NREQ*AW-1:0]   req_addr,
   input  logic [NREQ*BW-1:0]   req_burstcount,
   input  logic [NREQ*DW-1:0]   req_data,
   output logic [NREQ-1:0]      req_grant,
   output logic [NREQ-1:0]      req_rd,
   output logic [NREQ-1:0]      req_done,
   output logic                 txs_write,
   output logic [AW-1:0]        txs_address,
   output logic [BW-1:0]        txs_burstcount,
   output logic [DW-1:0]        txs_writedata,
   input  logic                 txs_waitrequest,
   output logic [NREQ*16-1:0]   stat_bursts
);

   localparam int              c_GW       = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam logic [c_GW-1:0] c_LAST_RST = c_GW'(NREQ - 1);
   localparam logic [BW-1:0]   c_MAXB     = BW'(MAX_BURST);

   txs_state_e       r_state;
   txs_state_e       w_state_nxt;

   logic [NREQ-1:0]  r_grant;
   logic [c_GW-1:0]  r_gidx;
   logic [c_GW-1:0]  r_last_grant;
   logic [AW-1:0]    r_addr;
   logic [BW-1:0]    r_bc;
   logic [BW-1:0]    r_left;
   logic             r_write;

   logic [NREQ-1:0]  w_pick;
   logic             w_any;
   logic [c_GW-1:0]  w_pick_idx;
   logic [AW-1:0]    w_pick_addr;
   logic [BW-1:0]    w_raw_bc;
   logic [BW-1:0]    w_pick_bc;
   logic             w_accept;
   logic             w_last_beat;

   txs_rr_pick #(
      .NREQ       (NREQ),
      .GW         (c_GW)
   ) u_pick (
      .req_valid  (req_valid),
      .last_grant (r_last_grant),
      .pick       (w_pick),
      .any        (w_any)
   );

   // Index, address and clamped length of the requester about to be granted.
   always_comb begin
      w_pick_idx  = '0;
      w_pick_addr = '0;
      w_raw_bc    = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (w_pick[i]) begin
            w_pick_idx  = c_GW'(i);
            w_pick_addr = req_addr[i*AW +: AW];
            w_raw_bc    = req_burstcount[i*BW +: BW];
         end
      end
      w_pick_bc = (w_raw_bc > c_MAXB) ? c_MAXB : w_raw_bc;
   end

   always_ff @(posedge clk125 or posedge rst) begin
      if (rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE: begin
            if (w_any) begin
               w_state_nxt = (w_pick_bc == '0) ? ZERO : BURST;
            end
         end
         BURST: begin
            if (w_last_beat) begin
               w_state_nxt = IDLE;
            end
         end
         ZERO: begin
            w_state_nxt = IDLE;
         end
         default: begin
            w_state_nxt = IDLE;
         end
      endcase
   end

   // Pop and done strobes are combinational so the FIFO advances on the
   // same edge that the slave takes the beat.
   always_comb begin
      w_accept      = r_write & ~txs_waitrequest;
      w_last_beat   = w_accept & (r_left == BW'(1));
      req_rd        = w_accept ? r_grant : '0;
      req_done      = (w_last_beat || (r_state == ZERO)) ? r_grant : '0;
      txs_writedata = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (r_gidx == c_GW'(i)) begin
            txs_writedata = req_data[i*DW +: DW];
         end
      end
   end

   always_ff @(posedge clk125 or posedge rst) begin
      if (rst) begin
         r_grant      <= '0;
         r_gidx       <= '0;
         r_last_grant <= c_LAST_RST;
         r_addr       <= '0;
         r_bc         <= '0;
         r_left       <= '0;
         r_write      <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_any) begin
                  r_grant <= w_pick;
                  r_gidx  <= w_pick_idx;
                  r_addr  <= w_pick_addr;
                  r_bc    <= w_pick_bc;
                  r_left  <= w_pick_bc;
                  r_write <= (w_pick_bc != '0);
               end
            end
            BURST: begin
               if (w_accept) begin
                  r_left <= r_left - BW'(1);
                  if (w_last_beat) begin
                     r_write      <= 1'b0;
                     r_grant      <= '0;
                     r_last_grant <= r_gidx;
                  end
               end
            end
            ZERO: begin
               r_grant      <= '0;
               r_last_grant <= r_gidx;
            end
            default: begin
               r_write <= 1'b0;
               r_grant <= '0;
            end
         endcase
      end
   end

   assign req_grant      = r_grant;
   assign txs_write      = r_write;
   assign txs_address    = r_addr;
   assign txs_burstcount = r_bc;

`ifdef TXS_ARB_STATS_EN
   generate
      for (genvar i = 0; i < NREQ; i++) begin : g_stats
         logic [15:0] r_cnt;
         always_ff @(posedge clk125 or posedge rst) begin
            if (rst) begin
               r_cnt <= '0;
            end else if (req_done[i]) begin
               r_cnt <= r_cnt + 16'd1;
            end
         end
         assign stat_bursts[i*16 +: 16] = r_cnt;
      end
   endgenerate
`else
   assign stat_bursts = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_txs_burst_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_txs_burst_arbiter
// Function : Self-checking bench for txs_burst_arbiter (NREQ = 2).
// Revision : 1.0
// ============================================================================
module tb_txs_burst_arbiter;
   import ovc_txs_pkg::*;

   localparam int NREQ = 2;
   localparam int AW   = c_AW;
   localparam int DW   = c_DW;
   localparam int BW   = c_BW;
   localparam int MAXB = c_MAX_BURST;

   logic                 clk125          = 1'b0;
   logic                 rst             = 1'b1;
   logic [NREQ-1:0]      req_valid       = '0;
   logic [NREQ*AW-1:0]   req_addr        = '0;
   logic [NREQ*BW-1:0]   req_burstcount  = '0;
   logic [NREQ*DW-1:0]   req_data        = '0;
   logic                 txs_waitrequest = 1'b0;
   logic [NREQ-1:0]      req_grant;
   logic [NREQ-1:0]      req_rd;
   logic [NREQ-1:0]      req_done;
   logic                 txs_write;
   logic [AW-1:0]        txs_address;
   logic [BW-1:0]        txs_burstcount;
   logic [DW-1:0]        txs_writedata;
   logic [NREQ*16-1:0]   stat_bursts;

   always #4 clk125 = ~clk125;

   txs_burst_arbiter #(
      .NREQ(NREQ), .AW(AW), .DW(DW), .BW(BW), .MAX_BURST(MAXB)
   ) dut (
      .clk125          (clk125),
      .rst             (rst),
      .req_valid       (req_valid),
      .req_addr        (req_addr),
      .req_burstcount  (req_burstcount),
      .req_data        (req_data),
      .req_grant       (req_grant),
      .req_rd          (req_rd),
      .req_done        (req_done),
      .txs_write       (txs_write),
      .txs_address     (txs_address),
      .txs_burstcount  (txs_burstcount),
      .txs_writedata   (txs_writedata),
      .txs_waitrequest (txs_waitrequest),
      .stat_bursts     (stat_bursts)
   );

   typedef struct packed {
      logic [AW-1:0] addr;
      logic [BW-1:0] bc;
   } burst_t;

   typedef struct {
      logic [NREQ-1:0] grant;
      logic [AW-1:0]   addr;
      logic [BW-1:0]   bc;
      int              writes;
      int              beats;
      int              t_start;
      int              t_end;
   } rec_t;

   typedef struct {
      logic [1:0]    valid;
      int            bc0;
      int            bc1;
      logic [1:0]    exp_grant;
      int            exp_beats;
      int            exp_bc;
      logic [AW-1:0] exp_addr;
   } vec_t;

   burst_t bq0[$];
   burst_t bq1[$];
   int     wcnt [NREQ];
   int     n_tests = 0;
   int     n_fail  = 0;
   int     cyc     = 0;

   // Reference model: who owns the bus and how many beats remain.
   int            m_owner = -1;
   int            m_left  = 0;
   int            m_last  = NREQ - 1;
   bit            m_zero  = 1'b0;
   logic [AW-1:0] m_addr  = '0;
   logic [BW-1:0] m_bc    = '0;
   int            m_stat [NREQ];

   logic               s_rst   = 1'b1;
   logic [NREQ-1:0]    s_valid = '0;
   logic [NREQ-1:0]    s_rd    = '0;
   logic [NREQ-1:0]    s_done  = '0;
   logic               s_wait  = 1'b0;
   logic [NREQ*AW-1:0] s_addr  = '0;
   logic [NREQ*BW-1:0] s_bc    = '0;

   rec_t cur;
   bit   rec_open = 1'b0;
   rec_t res[$];

   function automatic logic [DW-1:0] word_of(input int r, input int n);
      return {32'(r) + 32'hC0DE_0000, 64'h0, 32'(n)};
   endfunction

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s @%0t: got %h, want %h", name, $time, act, exp);
      end
   endtask

   task automatic push(input int r, input logic [AW-1:0] a, input int bc);
      burst_t b;
      b.addr = a;
      b.bc   = BW'(bc);
      if (r == 0) bq0.push_back(b);
      else        bq1.push_back(b);
   endtask

   task automatic drive();
      req_valid[0] = (bq0.size() != 0);
      req_valid[1] = (bq1.size() != 0);
      req_addr[0 +: AW]        = (bq0.size() != 0) ? bq0[0].addr : '0;
      req_addr[AW +: AW]       = (bq1.size() != 0) ? bq1[0].addr : '0;
      req_burstcount[0 +: BW]  = (bq0.size() != 0) ? bq0[0].bc : '0;
      req_burstcount[BW +: BW] = (bq1.size() != 0) ? bq1[0].bc : '0;
      for (int i = 0; i < NREQ; i++) req_data[i*DW +: DW] = word_of(i, wcnt[i]);
   endtask

   task automatic step();
      @(posedge clk125);
      #1;
   endtask

   // Per-cycle comparison against the model, plus burst recording.
   always @(negedge clk125) begin
      logic [NREQ-1:0]    e_grant;
      logic [NREQ-1:0]    e_rd;
      logic [NREQ-1:0]    e_done;
      logic               e_write;
      logic [AW-1:0]      e_addr;
      logic [BW-1:0]      e_bc;
      logic [NREQ*16-1:0] e_stat;
      cyc++;
      s_rst = rst; s_valid = req_valid; s_addr = req_addr; s_bc = req_burstcount;
      s_wait = txs_waitrequest; s_rd = req_rd; s_done = req_done;
      e_grant = '0; e_rd = '0; e_done = '0; e_write = 1'b0;
      e_addr = m_addr; e_bc = m_bc; e_stat = '0;
      if (rst) begin
         e_addr = '0;
         e_bc   = '0;
      end else if (m_owner >= 0) begin
         e_grant[m_owner] = 1'b1;
         e_write = !m_zero;
         if (m_zero) begin
            e_done = e_grant;
         end else if (!txs_waitrequest) begin
            e_rd = e_grant;
            if (m_left == 1) e_done = e_grant;
         end
      end
`ifdef TXS_ARB_STATS_EN
      if (!rst) for (int i = 0; i < NREQ; i++) e_stat[i*16 +: 16] = 16'(m_stat[i]);
`endif
      check("req_grant", req_grant, e_grant);
      check("txs_write", txs_write, e_write);
      check("req_rd", req_rd, e_rd);
      check("req_done", req_done, e_done);
      check("txs_address", txs_address, e_addr);
      check("txs_burstcount", txs_burstcount, e_bc);
      check("stat_bursts_cyc", stat_bursts, e_stat);
      if (e_write) check("txs_writedata", txs_writedata, word_of(m_owner, wcnt[m_owner]));

      if (rst) begin
         rec_open = 1'b0;
      end else begin
         if (!rec_open && req_grant != '0) begin
            rec_open = 1'b1;
            cur.grant = req_grant; cur.addr = txs_address; cur.bc = txs_burstcount;
            cur.writes = 0; cur.beats = 0; cur.t_start = cyc; cur.t_end = 0;
         end
         if (rec_open) begin
            if (txs_write) cur.writes++;
            if (|req_rd)   cur.beats++;
            if (|req_done) begin
               cur.t_end = cyc;
               res.push_back(cur);
               rec_open = 1'b0;
            end
         end
      end
   end

   // Advance model and emulate the requesters' show-ahead FIFOs.
   always @(posedge clk125) begin
      #1;
      if (s_rst) begin
         m_owner = -1; m_last = NREQ - 1; m_addr = '0; m_bc = '0; m_zero = 1'b0;
         for (int i = 0; i < NREQ; i++) m_stat[i] = 0;
         bq0.delete();
         bq1.delete();
      end else begin
         if (m_owner < 0) begin
            if (|s_valid) begin
               for (int k = NREQ; k >= 1; k--)
                  if (s_valid[(m_last + k) % NREQ]) m_owner = (m_last + k) % NREQ;
               m_addr = s_addr[m_owner*AW +: AW];
               m_left = int'(s_bc[m_owner*BW +: BW]);
               if (m_left > MAXB) m_left = MAXB;
               m_bc   = BW'(m_left);
               m_zero = (m_left == 0);
            end
         end else if (m_zero || !s_wait) begin
            if (!m_zero) m_left--;
            if (m_zero || m_left == 0) begin
               m_stat[m_owner]++;
               m_last  = m_owner;
               m_owner = -1;
            end
         end
         for (int i = 0; i < NREQ; i++) begin
            if (s_rd[i]) wcnt[i]++;
            if (s_done[i]) begin
               if (i == 0) void'(bq0.pop_front());
               else        void'(bq1.pop_front());
            end
         end
      end
      drive();
   end

   task automatic do_reset();
      step();
      rst = 1'b1;
      txs_waitrequest = 1'b0;
      repeat (3) step();
      rst = 1'b0;
      step();
      step();
      res.delete();
   endtask

   task automatic wait_idle();
      int n = 0;
      while ((bq0.size() != 0 || bq1.size() != 0 || m_owner >= 0) && n < 20000) begin
         step();
         n++;
      end
      check("idle_timeout", n < 20000, 1'b1);
      step();
      step();
   endtask

   initial begin
      vec_t tbl [7];
      int   n;
      logic [NREQ*16-1:0] e_stats;
      tbl[0] = '{2'b01, 4,  0,  2'b01, 4,  4,  23'h1000};
      tbl[1] = '{2'b10, 0,  0,  2'b10, 0,  0,  23'h2000};
      tbl[2] = '{2'b11, 8,  8,  2'b01, 8,  8,  23'h1000};
      tbl[3] = '{2'b10, 0,  40, 2'b10, 32, 32, 23'h2000};
      tbl[4] = '{2'b01, 32, 0,  2'b01, 32, 32, 23'h1000};
      tbl[5] = '{2'b01, 1,  0,  2'b01, 1,  1,  23'h1000};
      tbl[6] = '{2'b10, 0,  63, 2'b10, 32, 32, 23'h2000};

      // Reset state
      rst = 1'b1;
      repeat (2) step();
      check("reset_write", txs_write, 1'b0);
      check("reset_grant", req_grant, '0);
      check("reset_addr", txs_address, '0);
      check("reset_stats", stat_bursts, '0);

      // Single-burst vectors
      for (int v = 0; v < 7; v++) begin
         do_reset();
         if (tbl[v].valid[0]) push(0, 23'h1000, tbl[v].bc0);
         if (tbl[v].valid[1]) push(1, 23'h2000, tbl[v].bc1);
         wait_idle();
         check("tbl_nrec", res.size() > 0, 1'b1);
         if (res.size() > 0) begin
            check("tbl_grant", res[0].grant, tbl[v].exp_grant);
            check("tbl_beats", res[0].beats, tbl[v].exp_beats);
            check("tbl_writes", res[0].writes, tbl[v].exp_beats);
            check("tbl_bc", res[0].bc, tbl[v].exp_bc);
            check("tbl_addr", res[0].addr, tbl[v].exp_addr);
            check("tbl_len", res[0].t_end - res[0].t_start,
                  (tbl[v].exp_beats > 0) ? tbl[v].exp_beats - 1 : 0);
         end
      end

      // Contention: 0,1,0,1 with 8 beats each and one idle cycle between
      do_reset();
      push(0, 23'h1100, 8); push(0, 23'h1200, 8);
      push(1, 23'h2100, 8); push(1, 23'h2200, 8);
      wait_idle();
      check("cont_nrec", res.size(), 4);
      if (res.size() == 4) begin
         for (int k = 0; k < 4; k++) begin
            check("cont_grant", res[k].grant, (k % 2 == 0) ? 2'b01 : 2'b10);
            check("cont_writes", res[k].writes, 8);
            if (k > 0) check("cont_gap", res[k].t_start - res[k-1].t_end, 2);
         end
      end

      // Stall during a 6-beat burst
      do_reset();
      txs_waitrequest = 1'b1;
      push(0, 23'h7000, 6);
      repeat (25) step();
      txs_waitrequest = 1'b0;
      repeat (6) step();
      txs_waitrequest = 1'b1;
      repeat (6) step();
      txs_waitrequest = 1'b0;
      wait_idle();
      check("stall_nrec", res.size(), 1);
      if (res.size() > 0) check("stall_beats", res[0].beats, 6);

      // Zero-length grant, then requester 0 must win next
      do_reset();
      push(1, 23'h2400, 0);
      wait_idle();
      push(0, 23'h1400, 2);
      push(1, 23'h2500, 2);
      wait_idle();
      check("zero_nrec", res.size(), 3);
      if (res.size() == 3) begin
         check("zero_grant", res[0].grant, 2'b10);
         check("zero_writes", res[0].writes, 0);
         check("zero_next", res[1].grant, 2'b01);
      end

      // Reset in the middle of an 8-beat burst
      do_reset();
      push(0, 23'h3000, 8);
      push(1, 23'h4000, 8);
      n = 0;
      while (!(rec_open && cur.beats >= 2) && n < 200) begin
         step();
         n++;
      end
      check("mid_reached", n < 200, 1'b1);
      rst = 1'b1;
      @(negedge clk125);
      #1;
      check("mid_rst_write", txs_write, 1'b0);
      check("mid_rst_grant", req_grant, '0);
      repeat (2) step();
      rst = 1'b0;
      step();
      step();
      res.delete();
      push(1, 23'h6000, 8);
      push(0, 23'h5000, 8);
      wait_idle();
      check("post_rst_nrec", res.size(), 2);
      if (res.size() > 0) begin
         check("post_rst_grant", res[0].grant, 2'b01);
         check("post_rst_beats", res[0].beats, 8);
         check("post_rst_addr", res[0].addr, 23'h5000);
      end

      // Burst statistics
      do_reset();
      for (int k = 0; k < 3; k++) push(0, 23'h100 * k, 2);
      for (int k = 0; k < 2; k++) push(1, 23'h800 + 23'h100 * k, 3);
      wait_idle();
`ifdef TXS_ARB_STATS_EN
      e_stats = {16'd2, 16'd3};
`else
      e_stats = '0;
`endif
      check("stat_bursts", stat_bursts, e_stats);

      // Randomized traffic against the model
      do_reset();
      for (int it = 0; it < 800; it++) begin
         step();
         txs_waitrequest = ($urandom_range(0, 9) < 3);
         if ($urandom_range(0, 5) == 0)
            push(int'($urandom_range(0, 1)), AW'($urandom), int'($urandom_range(0, 40)));
      end
      txs_waitrequest = 1'b0;
      wait_idle();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
